// File: rtl/key_conditioner.sv
// key_conditioner: synchronize, debounce and pulse-shape active-low pushbuttons with optional auto-repeat
module key_conditioner #(
  parameter int NUM_KEYS             = 4,
  parameter int DEBOUNCE_CYCLES      = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 5_000_000
) (
  input  logic                clk_50MHz,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_fire,
  output logic [NUM_KEYS-1:0] key_release
);
  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int MAX_P  = (MAX_AB > REPEAT_PERIOD_CYCLES) ? MAX_AB : REPEAT_PERIOD_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic [1:0]    r_sync;
    logic [CW-1:0] r_db_cnt;
    logic [CW-1:0] r_rep_cnt;
    logic          r_stable;
    logic          r_level;
    logic          r_en;
    logic          r_press;
    logic          r_fire;
    logic          r_release;
    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] w_rep_cnt;
    logic          w_press;
    logic          w_fire;
    logic          w_release;
    logic          w_sync;
    logic          w_rise;
    logic          w_fall;
    assign w_sync = ~r_sync[1];
    assign w_rise = r_stable & ~r_level;
    assign w_fall = ~r_stable & r_level;
    // Two-flop synchronizer and debouncer: stable level flips after DEBOUNCE_CYCLES consecutive disagreements
    always_ff @(posedge clk_50MHz) begin
      if (reset) begin
        r_sync   <= 2'b11;
        r_db_cnt <= '0;
        r_stable <= 1'b0;
      end else begin
        r_sync <= {r_sync[0], key_n[i]};
        if (w_sync == r_stable) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_db_cnt <= '0;
          r_stable <= ~r_stable;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end
    // Repeat FSM next state and pulses; a release overrides any coincident repeat expiry
    always_comb begin
      w_next    = r_state;
      w_rep_cnt = r_rep_cnt;
      w_press   = 1'b0;
      w_fire    = 1'b0;
      w_release = 1'b0;
      if (w_fall) begin
        w_release = 1'b1;
        w_next    = IDLE;
        w_rep_cnt = '0;
      end else begin
        case (r_state)
          IDLE: begin
            w_rep_cnt = '0;
            if (w_rise) begin
              w_press = 1'b1;
              w_fire  = 1'b1;
              w_next  = DELAY;
            end
          end
          DELAY: begin
            if (!r_en) begin
              w_rep_cnt = '0;
            end else if (r_rep_cnt == CW'(REPEAT_DELAY_CYCLES - 1)) begin
              w_fire    = 1'b1;
              w_rep_cnt = '0;
              w_next    = REPEAT;
            end else begin
              w_rep_cnt = r_rep_cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (!r_en) begin
              w_rep_cnt = '0;
              w_next    = DELAY;
            end else if (r_rep_cnt == CW'(REPEAT_PERIOD_CYCLES - 1)) begin
              w_fire    = 1'b1;
              w_rep_cnt = '0;
            end else begin
              w_rep_cnt = r_rep_cnt + 1'b1;
            end
          end
          default: begin
            w_next    = IDLE;
            w_rep_cnt = '0;
          end
        endcase
      end
    end
    // FSM state, repeat counter and registered outputs
    always_ff @(posedge clk_50MHz) begin
      if (reset) begin
        r_state   <= IDLE;
        r_rep_cnt <= '0;
        r_level   <= 1'b0;
        r_en      <= 1'b0;
        r_press   <= 1'b0;
        r_fire    <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_next;
        r_rep_cnt <= w_rep_cnt;
        r_level   <= r_stable;
        r_en      <= repeat_en[i];
        r_press   <= w_press;
        r_fire    <= w_fire;
        r_release <= w_release;
      end
    end
    assign key_level[i]   = r_level;
    assign key_press[i]   = r_press;
    assign key_fire[i]    = r_fire;
    assign key_release[i] = r_release;
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed cycle-by-cycle checks of the key conditioner with short timing parameters
module tb_key_conditioner;
  logic       clk_50MHz = 1'b0;
  logic       reset     = 1'b1;
  logic [3:0] key_n     = 4'hF;
  logic [3:0] repeat_en = 4'h0;
  logic [3:0] key_level, key_press, key_fire, key_release;
  logic [15:0] obs, exp_v;
  logic [3:0] el, ep, ef, er;
  int n_cmp = 0;
  int n_err = 0;

  key_conditioner #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(20), .REPEAT_PERIOD_CYCLES(8)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .key_n(key_n), .repeat_en(repeat_en),
    .key_level(key_level), .key_press(key_press), .key_fire(key_fire), .key_release(key_release)
  );

  always #5 clk_50MHz = ~clk_50MHz;
  assign obs = {key_level, key_press, key_fire, key_release};

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; key_n = 4'hF; repeat_en = 4'h0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; key_n = 4'h0; repeat_en = 4'hF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (obs !== 16'h0) begin
        n_err++;
        $display("FAIL reset c=%0d got=%h exp=%h", c, obs, 16'h0);
      end
    end
    do_reset();
    n_cmp++;
    if (obs !== 16'h0) begin
      n_err++;
      $display("FAIL reset_idle got=%h exp=%h", obs, 16'h0);
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      key_n[0] = (c > 29);
      tick();
      el = 0; ep = 0; ef = 0; er = 0;
      el[0] = (c >= 6 && c < 36); ep[0] = (c == 6); ef[0] = (c == 6); er[0] = (c == 36);
      exp_v = {el, ep, ef, er};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL clean_press c=%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int c = 0; c < 26; c++) begin
      key_n[1] = (c < 12) ? ((c / 2) % 2 == 1) : 1'b0;
      tick();
      el = 0; ep = 0; ef = 0; er = 0;
      el[1] = (c >= 18); ep[1] = (c == 18); ef[1] = (c == 18);
      exp_v = {el, ep, ef, er};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL bounce c=%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_auto_repeat();
    do_reset();
    for (int c = 0; c < 72; c++) begin
      repeat_en[2] = 1'b1;
      key_n[2] = (c > 59);
      tick();
      el = 0; ep = 0; ef = 0; er = 0;
      el[2] = (c >= 6 && c < 66); ep[2] = (c == 6);
      ef[2] = (c inside {6, 26, 34, 42, 50, 58}); er[2] = (c == 66);
      exp_v = {el, ep, ef, er};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL auto_repeat c=%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_repeat_toggle();
    do_reset();
    for (int c = 0; c < 90; c++) begin
      repeat_en[2] = !(c >= 30 && c <= 39);
      key_n[2] = (c > 79);
      tick();
      el = 0; ep = 0; ef = 0; er = 0;
      el[2] = (c >= 6 && c < 86); ep[2] = (c == 6);
      ef[2] = (c inside {6, 26, 60, 68, 76, 84}); er[2] = (c == 86);
      exp_v = {el, ep, ef, er};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL repeat_toggle c=%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    for (int c = 0; c < 46; c++) begin
      repeat_en[2] = 1'b1;
      key_n[2] = 1'b0;
      reset = (c == 30);
      tick();
      el = 0; ep = 0; ef = 0; er = 0;
      if (c < 30) begin
        el[2] = (c >= 6); ep[2] = (c == 6); ef[2] = (c inside {6, 26});
      end else if (c > 30) begin
        el[2] = (c >= 37); ep[2] = (c == 37); ef[2] = (c == 37);
      end
      exp_v = {el, ep, ef, er};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_hold c=%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      key_n[0] = (c > 9);
      key_n[3] = (c > 9);
      tick();
      el = 0; ep = 0; ef = 0; er = 0;
      el[0] = (c >= 6 && c < 16); el[3] = el[0];
      ep[0] = (c == 6); ep[3] = ep[0];
      ef[0] = (c == 6); ef[3] = ef[0];
      er[0] = (c == 16); er[3] = er[0];
      exp_v = {el, ep, ef, er};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL simultaneous c=%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_repeat_toggle();
    test_reset_mid_hold();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input-side companion to the time display path. It converts the raw, active-low DE2 pushbuttons into clean, clock-synchronous control strobes for the clock, stopwatch and timer logic (inc_minutes, inc_hours, start/stop, and so on). For each key it provides:
- 2-flop synchronization and debouncing;
- single-cycle press and release pulses;
- optional auto-repeat while the key is held.

Every key is an independent channel. It sits between the KEY pins and the clock core, in the 50 MHz domain.

## Interface
Parameters:
- NUM_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 1_000_000: consecutive cycles the synchronized input must differ from the stable level before that level flips (20 ms). Must be ≥1.
- REPEAT_DELAY_CYCLES, 25_000_000: cycles from the press pulse to the first auto-repeat (0.5 s). Must be ≥1.
- REPEAT_PERIOD_CYCLES, 5_000_000: cycles between subsequent auto-repeats (100 ms). Must be ≥1.

Ports:
- clk_50MHz  input  1  system clock. One clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- key_n  input  NUM_KEYS  raw pushbuttons, active-low, asynchronous to clk_50MHz.
- repeat_en  input  NUM_KEYS  per-key auto-repeat enable (synchronous).
- key_level  output  NUM_KEYS  debounced state, 1 = pressed.
- key_press  output  NUM_KEYS  1-cycle pulse on each debounced press.
- key_fire  output  NUM_KEYS  1-cycle pulse on the press and on every auto-repeat.
- key_release  output  NUM_KEYS  1-cycle pulse on each debounced release.

## Operation
Per channel i:
- **Synchronizer:** two flops on key_n[i]; reset value 1 (released). The synchronized, inverted value is called sync_i (1 = pressed).
- **Debouncer:**
  - Counter clears whenever sync_i == stable_i.
  - Counter increments each cycle that sync_i != stable_i.
  - When the counter reaches DEBOUNCE_CYCLES, stable_i toggles and the counter clears.
  - key_level[i] = stable_i, registered.
- **Repeat FSM**, states IDLE, DELAY, REPEAT:
  - IDLE: on stable_i 0→1, pulse key_press[i] and key_fire[i]; clear the repeat counter; go to DELAY.
  - DELAY: the repeat counter advances only while repeat_en[i]=1 and clears while it is 0. On reaching REPEAT_DELAY_CYCLES, pulse key_fire[i], clear the counter, go to REPEAT.
  - REPEAT: same counting rule. On reaching REPEAT_PERIOD_CYCLES, pulse key_fire[i] and clear the counter. If repeat_en[i]=0, go back to DELAY, so a re-enable restarts the full delay.
  - Any state: on stable_i 1→0, pulse key_release[i] and go to IDLE.
- **Simultaneous events:** release and repeat expiry in the same cycle means release wins: no key_fire, key_release pulses.
- **Channel independence:** channels are fully independent. Simultaneous presses on several keys produce pulses in the same cycle on each bit.
- **Counter widths:** counters are sized by $clog2 of the largest parameter plus 1. Counters never wrap, because they clear on match.

## Timing
- **Reset:** all outputs are 0 in the cycle after reset is sampled high.
  - All FSMs return to IDLE, stable levels become 0, counters clear, synchronizers go to 1.
  - Reset asserted mid-hold aborts the channel without a release pulse.
  - A key still held when reset deasserts is treated as a new press.
- **Press latency:** key_level rises, and key_press/key_fire pulse, exactly DEBOUNCE_CYCLES+2 cycles after the first edge that samples key_n low. This requires key_n to stay low throughout.
- **Release latency:** key_release pulses, and key_level falls, DEBOUNCE_CYCLES+2 cycles after the first edge that samples key_n high.
- **Bounce:** any bounce shorter than DEBOUNCE_CYCLES restarts the count and produces no pulse.
- **Repeat cadence:** the first repeat comes REPEAT_DELAY_CYCLES after key_press. Later repeats follow every REPEAT_PERIOD_CYCLES, with repeat_en held at 1.
- **Pulse width:** all pulses are exactly one cycle. key_press implies key_fire in the same cycle.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=8, NUM_KEYS=4. Cycle 0 is the first edge that samples key_n low.

1. **Clean press, no repeat.** key_n[0] low on cycles 0–29, repeat_en=0 → key_level[0] rises at cycle 6; key_press[0] and key_fire[0] pulse once at cycle 6, with no further key_fire; key_release[0] pulses at cycle 36 and key_level[0] falls at cycle 36.
2. **Bouncing press.** key_n[1] toggles every 2 cycles for cycles 0–11, then stays low → no pulses during the bounce; a single key_press[1] at cycle 18 (12+6).
3. **Auto-repeat.** repeat_en[2]=1, key_n[2] low on cycles 0–59 → key_fire[2] at 6, 26, 34, 42, 50, 58; key_press[2] only at 6; key_release[2] at 66; no key_fire at 66, since release wins over the coincident repeat.
4. **Repeat enable toggled.** Scenario 3 setup, with repeat_en[2] dropped on cycles 30–39 → no key_fire in that window; next key_fire at cycle 60 (40+20), then 68.
5. **Reset mid-hold.** Key held as in scenario 3, reset high at cycle 30 for 1 cycle → all outputs 0 from cycle 31 with no key_release; key still held after reset → fresh key_press 6 cycles after reset deasserts.
6. **Simultaneous keys.** key_n[0] and key_n[3] pressed in the same cycle → key_press[0] and key_press[3] both pulse at cycle 6; bits 1 and 2 stay 0.
